// File: rtl/ipb_pkg.sv
// Shared IPbus types and constants for the ipb_intf register endpoint.
package ipb_pkg;

  localparam int IPB_DATA_W = 32;
  localparam int IPB_ADDR_W = 32;

  // Master -> slave bus.
  typedef struct packed {
    logic [IPB_ADDR_W-1:0] addr;
    logic [IPB_DATA_W-1:0] wdata;
    logic                  strobe;
    logic                  write;
  } ipb_wbus_t;

  // Slave -> master bus.
  typedef struct packed {
    logic [IPB_DATA_W-1:0] rdata;
    logic                  ack;
    logic                  err;
  } ipb_rbus_t;

  // Address decode classes.
  typedef enum logic [1:0] {
    DEC_REG     = 2'd0,
    DEC_ID      = 2'd1,
    DEC_ILLEGAL = 2'd2
  } ipb_dec_e;

  // Classify an address from three pre-extracted facts:
  //   upper_zero : every bit above the compared field is zero
  //   range_bit  : the bit of weight NREGS
  //   low_zero   : every bit below range_bit is zero
  // Word NREGS is the ID word; anything at or above NREGS+1 is illegal.
  function automatic ipb_dec_e ipb_decode(input logic upper_zero,
                                          input logic range_bit,
                                          input logic low_zero);
    ipb_dec_e dec;
    if (!upper_zero) begin
      dec = DEC_ILLEGAL;
    end else if (!range_bit) begin
      dec = DEC_REG;
    end else if (low_zero) begin
      dec = DEC_ID;
    end else begin
      dec = DEC_ILLEGAL;
    end
    return dec;
  endfunction

endpackage

// File: rtl/ipb_intf_reg_bank.sv
// NREGS x 32-bit register array: synchronous write, combinational read,
// synchronous active-high clear.
module ipb_intf_reg_bank
  import ipb_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [IPB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [IPB_DATA_W-1:0] rdata
);

  logic [IPB_DATA_W-1:0] regs_q [NREGS];
  logic [IPB_DATA_W-1:0] regs_d [NREGS];

  // Next-state: only the addressed word changes, and only on a write.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (wr_en && (waddr == IDX_W'(i))) begin
        regs_d[i] = wdata;
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
  end

  // Register storage with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {IPB_DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Combinational read port.
  assign rdata = regs_q[raddr];

endmodule

// File: rtl/ipb_intf.sv
// IPbus leaf slave: NREGS read/write words, a read-only ID word at
// address NREGS, and err for anything else. All rbus outputs registered;
// a new request is only taken while no response is being presented, so
// ack/err are single-cycle pulses.
module ipb_intf
  import ipb_pkg::*;
#(
  parameter int          NREGS      = 16,
  parameter int          ADDR_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h1BB0_0001
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] ipb_addr,
  input  logic [31:0]           ipb_wdata,
  input  logic                  ipb_strobe,
  input  logic                  ipb_write,
  output logic [31:0]           ipb_rdata,
  output logic                  ipb_ack,
  output logic                  ipb_err
);

  localparam int IDX_W = $clog2(NREGS);
  localparam int CMP_W = IDX_W + 1;

  logic                  upper_zero_s;
  logic                  range_bit_s;
  logic                  low_zero_s;
  ipb_dec_e              dec_s;
  logic                  accept_s;
  logic                  wr_en_s;
  logic [IPB_DATA_W-1:0] bank_rdata_s;

  ipb_rbus_t rbus_q;
  ipb_rbus_t rbus_d;

  // Address fields: the compared field is IDX_W+1 bits; everything above
  // it must be zero for the access to be legal.
  assign upper_zero_s = ((ipb_addr >> CMP_W) == {ADDR_WIDTH{1'b0}});
  assign range_bit_s  = ipb_addr[IDX_W];
  assign low_zero_s   = (ipb_addr[IDX_W-1:0] == {IDX_W{1'b0}});
  assign dec_s        = ipb_decode(upper_zero_s, range_bit_s, low_zero_s);

  // Take a request only when no response is currently on the bus.
  assign accept_s = ipb_strobe && !rbus_q.ack && !rbus_q.err;

  ipb_intf_reg_bank #(
    .NREGS (NREGS),
    .IDX_W (IDX_W)
  ) u_reg_bank (
    .CLK   (CLK),
    .RST   (RST),
    .wr_en (wr_en_s),
    .waddr (ipb_addr[IDX_W-1:0]),
    .wdata (ipb_wdata),
    .raddr (ipb_addr[IDX_W-1:0]),
    .rdata (bank_rdata_s)
  );

  // Decode the accepted request into the next response and write enable.
  always_comb begin
    rbus_d.rdata = {IPB_DATA_W{1'b0}};
    rbus_d.ack   = 1'b0;
    rbus_d.err   = 1'b0;
    wr_en_s      = 1'b0;
    if (accept_s) begin
      case (dec_s)
        DEC_REG: begin
          rbus_d.ack = 1'b1;
          if (ipb_write) begin
            wr_en_s = 1'b1;
          end else begin
            rbus_d.rdata = bank_rdata_s;
          end
        end
        DEC_ID: begin
          if (ipb_write) begin
            rbus_d.err = 1'b1;
          end else begin
            rbus_d.ack   = 1'b1;
            rbus_d.rdata = ID_VALUE;
          end
        end
        DEC_ILLEGAL: begin
          rbus_d.err = 1'b1;
        end
        default: begin
          rbus_d.err = 1'b1;
        end
      endcase
    end else begin
      rbus_d.ack = 1'b0;
    end
  end

  // Response register; reset drops any in-flight request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rbus_q <= '{rdata: {IPB_DATA_W{1'b0}}, ack: 1'b0, err: 1'b0};
    end else begin
      rbus_q <= rbus_d;
    end
  end

  assign ipb_rdata = rbus_q.rdata;
  assign ipb_ack   = rbus_q.ack;
  assign ipb_err   = rbus_q.err;

endmodule

// File: tb/tb_ipb_intf.sv
// Directed-vector bench for ipb_intf with a queue-based scoreboard.
module tb_ipb_intf;
  import ipb_pkg::*;

  localparam int          NREGS = 16;
  localparam logic [31:0] ID    = 32'h1BB0_0001;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] ipb_addr = 32'h0;
  logic [31:0] ipb_wdata = 32'h0;
  logic        ipb_strobe = 1'b0;
  logic        ipb_write = 1'b0;
  logic [31:0] ipb_rdata;
  logic        ipb_ack;
  logic        ipb_err;

  int n_vec = 0;
  int n_bad = 0;

  ipb_rbus_t exp_q[$];
  string     name_q[$];

  ipb_intf #(.NREGS(NREGS), .ADDR_WIDTH(32), .ID_VALUE(ID)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ipb_addr   (ipb_addr),
    .ipb_wdata  (ipb_wdata),
    .ipb_strobe (ipb_strobe),
    .ipb_write  (ipb_write),
    .ipb_rdata  (ipb_rdata),
    .ipb_ack    (ipb_ack),
    .ipb_err    (ipb_err)
  );

  always #5 CLK = ~CLK;

  // Monitor: whenever the DUT presents a response, pop and compare.
  initial begin
    ipb_rbus_t e;
    string     nm;
    forever begin
      @(posedge CLK);
      #1;
      if (ipb_ack || ipb_err) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_rsp: got ack=%0b err=%0b rdata=%h, none expected",
                   ipb_ack, ipb_err, ipb_rdata);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (ipb_ack !== e.ack || ipb_err !== e.err || ipb_rdata !== e.rdata) begin
            n_bad++;
            $display("FAIL %s: got ack=%0b err=%0b rdata=%h, expected ack=%0b err=%0b rdata=%h",
                     nm, ipb_ack, ipb_err, ipb_rdata, e.ack, e.err, e.rdata);
          end
        end
      end
    end
  end

  // Check that every queued expectation has been consumed.
  task automatic check_drained(input string nm);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_no_rsp: %0d responses missing, expected 0", nm, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // One single-cycle transaction; strobe dropped in the response cycle.
  task automatic xact(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                      input logic e_ack, input logic e_err, input logic [31:0] e_rd,
                      input string nm);
    @(negedge CLK);
    ipb_addr   = a;
    ipb_write  = wr;
    ipb_wdata  = wd;
    ipb_strobe = 1'b1;
    exp_q.push_back('{rdata: e_rd, ack: e_ack, err: e_err});
    name_q.push_back(nm);
    @(negedge CLK);
    ipb_strobe = 1'b0;
    ipb_write  = 1'b1;          // ignored while strobe is low
    ipb_wdata  = 32'hDEAD_BEEF;
    check_drained(nm);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input string nm);
    xact(a, 1'b1, d, 1'b1, 1'b0, 32'h0, nm);
  endtask

  task automatic do_rd(input logic [31:0] a, input logic [31:0] d, input string nm);
    xact(a, 1'b0, 32'h0, 1'b1, 1'b0, d, nm);
  endtask

  task automatic do_err(input logic [31:0] a, input logic wr, input string nm);
    xact(a, wr, 32'h1234_5678, 1'b0, 1'b1, 32'h0, nm);
  endtask

  initial begin
    logic [31:0] pats [4];
    pats[0] = 32'hFFFF_FFFF;
    pats[1] = 32'hCCCC_CCCC;
    pats[2] = 32'hECEC_ECEC;
    pats[3] = 32'hAAAA_AAAA;

    repeat (2) @(negedge CLK);
    RST = 1'b0;

    // Outputs after reset.
    n_vec++;
    if (ipb_ack !== 1'b0 || ipb_err !== 1'b0 || ipb_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ack=%0b err=%0b rdata=%h, expected 0/0/0",
               ipb_ack, ipb_err, ipb_rdata);
    end

    do_rd(32'd0, 32'h0, "rd0_after_reset");

    for (int i = 0; i < 4; i++) begin
      do_wr(32'd0, pats[i], "wr0_pat");
      do_rd(32'd0, pats[i], "rd0_pat");
    end

    do_wr(32'd3, 32'h1111_1111, "wr3");
    do_wr(NREGS - 1, 32'h5555_5555, "wr_last");
    do_rd(32'd3, 32'h1111_1111, "rd3");
    do_rd(NREGS - 1, 32'h5555_5555, "rd_last");
    do_rd(32'd0, 32'hAAAA_AAAA, "rd0_unchanged");

    do_rd(NREGS, ID, "rd_id");
    do_err(NREGS, 1'b1, "wr_id_err");
    do_rd(NREGS, ID, "rd_id_again");

    do_err(NREGS + 1, 1'b0, "rd_nregs1_err");
    do_err(NREGS + 1, 1'b1, "wr_nregs1_err");
    do_err(32'h8000_0000, 1'b0, "rd_hi_err");
    do_err(32'h8000_0000, 1'b1, "wr_hi_err");
    do_err(32'h8000_0003, 1'b1, "wr_hi3_err");
    do_rd(32'd0, 32'hAAAA_AAAA, "rd0_after_err");
    do_rd(32'd3, 32'h1111_1111, "rd3_after_err");
    do_rd(NREGS - 1, 32'h5555_5555, "rd_last_after_err");

    // Strobe held for 6 cycles: three responses on alternating cycles.
    @(negedge CLK);
    ipb_addr   = 32'd3;
    ipb_write  = 1'b0;
    ipb_strobe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{rdata: 32'h1111_1111, ack: 1'b1, err: 1'b0});
      name_q.push_back("held_strobe");
    end
    repeat (6) @(negedge CLK);
    ipb_strobe = 1'b0;
    check_drained("held_strobe");

    // Reset in the middle of a write: dropped, no response, bank cleared.
    @(negedge CLK);
    RST        = 1'b1;
    ipb_addr   = 32'd5;
    ipb_write  = 1'b1;
    ipb_wdata  = 32'h7777_7777;
    ipb_strobe = 1'b1;
    @(negedge CLK);
    RST        = 1'b0;
    ipb_strobe = 1'b0;
    @(negedge CLK);
    n_vec++;
    if (ipb_ack !== 1'b0 || ipb_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_drop: got ack=%0b err=%0b, expected 0/0", ipb_ack, ipb_err);
    end
    for (int i = 0; i < NREGS; i++) begin
      do_rd(i, 32'h0, "rd_after_reset");
    end
    do_rd(NREGS, ID, "rd_id_after_reset");

    repeat (3) @(negedge CLK);
    check_drained("final");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
